// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Feeds an external hex decoder one digit at a time and double-buffers the displayed value.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic                    load_ack,
    output logic [3:0]              dec_num,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [NUM_DIGITS-1:0]   active_blank;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic                    pending;
    logic                    supp;

    // Dark if blanked, or a leading zero (this nibble and all higher ones zero); digit 0 always shows.
    function automatic logic digit_suppressed(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   blk,
        input logic                    lz,
        input logic [IDX_W-1:0]        d
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(d) && val[4*k +: 4] != 4'd0)
                upper_zero = 1'b0;
        end
        return blk[d] | (lz & (d != '0) & upper_zero);
    endfunction

    assign supp       = digit_suppressed(active_val, active_blank, lz_suppress, idx);
    assign dec_num    = active_val[4*idx +: 4];
    assign frame_done = (state == ST_FRAME);
    assign load_ack   = frame_done & (pending | load);
    assign an_out     = (state == ST_DRIVE && !supp) ? ~(NUM_DIGITS'(1) << idx) : '1;

    // Shadow buffer is pure data; the pending flag qualifies it.
    always_ff @(posedge Clk) begin
        if (load) begin
            shadow_val   <= value_in;
            shadow_blank <= blank_in;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= '0;
            seg_out      <= 7'b1111111;
            active_val   <= '0;
            active_blank <= '1;
            pending      <= 1'b0;
        end else begin
            if (state == ST_FRAME)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;

            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        seg_out <= supp ? 7'b1111111 : dec_seg;
                        state   <= ST_DRIVE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_FRAME;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_BLANK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FRAME: begin
                    // A load landing in this very cycle wins over the older shadow copy.
                    if (load) begin
                        active_val   <= value_in;
                        active_blank <= blank_in;
                    end else if (pending) begin
                        active_val   <= shadow_val;
                        active_blank <= shadow_blank;
                    end
                    idx   <= '0;
                    cnt   <= '0;
                    state <= ST_BLANK;
                end
                default: begin
                    idx   <= '0;
                    cnt   <= '0;
                    state <= ST_BLANK;
                end
            endcase
        end
    end

endmodule
